// File: rtl/hex_digit_monitor.sv
// Receive-side checker for a 7-segment HEX bus: glitch filter, digit decode,
// successor check and digit-change period measurement. HEX_MON_ERR_COUNT_EN adds err_count.
module hex_digit_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int PERIOD_W      = 26,
    parameter int EXP_PERIOD    = 50000000,
    parameter int PERIOD_TOL    = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [6:0]          seg_in,
    output logic [3:0]          digit,
    output logic                digit_valid,
    output logic                change,
    output logic                seq_err,
    output logic                bad_pat,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                rate_err
`ifdef HEX_MON_ERR_COUNT_EN
    ,
    output logic [7:0]          err_count
`endif
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [PERIOD_W:0] RATE_LO    = (PERIOD_W + 1)'(EXP_PERIOD - PERIOD_TOL);
    localparam logic [PERIOD_W:0] RATE_HI    = (PERIOD_W + 1)'(EXP_PERIOD + PERIOD_TOL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_TRACK
    } state_t;

    state_t              state;
    logic [6:0]          seg_q;
    logic [6:0]          cand;
    logic [6:0]          acc_pat;
    logic [CNT_W-1:0]    stab_cnt;
    logic [PERIOD_W-1:0] per_cnt;

    logic                dec_legal;
    logic [3:0]          dec_digit;
    logic                accept;
    logic [3:0]          next_digit;
    logic [PERIOD_W:0]   per_ext;
    logic                out_of_rate;

    always_comb begin
        dec_legal = 1'b1;
        dec_digit = 4'd0;
        case (cand)
            7'h40:   dec_digit = 4'd0;
            7'h79:   dec_digit = 4'd1;
            7'h24:   dec_digit = 4'd2;
            7'h30:   dec_digit = 4'd3;
            7'h19:   dec_digit = 4'd4;
            7'h12:   dec_digit = 4'd5;
            7'h02:   dec_digit = 4'd6;
            7'h78:   dec_digit = 4'd7;
            7'h00:   dec_digit = 4'd8;
            7'h18:   dec_digit = 4'd9;
            default: dec_legal = 1'b0;
        endcase
    end

    // A pattern fires once: only when it is stable and differs from the last accepted one.
    assign accept      = (stab_cnt == STABLE_MAX) && (cand != acc_pat);
    assign next_digit  = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    assign per_ext     = {1'b0, per_cnt};
    assign out_of_rate = (per_ext < RATE_LO) || (per_ext > RATE_HI);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            seg_q        <= 7'h7F;
            cand         <= 7'h7F;
            acc_pat      <= 7'h7F;
            stab_cnt     <= '0;
            per_cnt      <= '0;
            digit        <= 4'd0;
            digit_valid  <= 1'b0;
            change       <= 1'b0;
            seq_err      <= 1'b0;
            bad_pat      <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            rate_err     <= 1'b0;
        end else begin
            seg_q        <= seg_in;
            change       <= 1'b0;
            seq_err      <= 1'b0;
            bad_pat      <= 1'b0;
            period_valid <= 1'b0;
            rate_err     <= 1'b0;

            if (seg_q == cand) begin
                if (stab_cnt != STABLE_MAX) begin
                    stab_cnt <= stab_cnt + 1'b1;
                end
            end else begin
                cand     <= seg_q;
                stab_cnt <= CNT_W'(1);
            end

            if (per_cnt != '1) begin
                per_cnt <= per_cnt + 1'b1;
            end

            if (accept) begin
                acc_pat <= cand;
                if (dec_legal) begin
                    digit       <= dec_digit;
                    digit_valid <= 1'b1;
                    change      <= 1'b1;
                    per_cnt     <= PERIOD_W'(1);
                    case (state)
                        S_IDLE: begin
                            state <= S_FIRST;
                        end
                        S_FIRST: begin
                            seq_err      <= (dec_digit != next_digit);
                            period       <= per_cnt;
                            period_valid <= 1'b1;
                            state        <= S_TRACK;
                        end
                        default: begin
                            seq_err      <= (dec_digit != next_digit);
                            period       <= per_cnt;
                            period_valid <= 1'b1;
                            rate_err     <= out_of_rate;
                            state        <= S_TRACK;
                        end
                    endcase
                end else begin
                    // Illegal pattern breaks the chain; the next legal digit starts afresh.
                    bad_pat <= 1'b1;
                    state   <= S_IDLE;
                end
            end
        end
    end

`ifdef HEX_MON_ERR_COUNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_count <= 8'd0;
        end else if ((seq_err || bad_pat || rate_err) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hex_digit_monitor.sv
// Bench for hex_digit_monitor: directed vector table, hand sequences and random
// segments, every cycle compared against a window-based reference model.
module tb_hex_digit_monitor;

    localparam int S   = 4;
    localparam int PW  = 26;
    localparam int EXP = 20;
    localparam int TOL = 1;
    localparam int NV  = 30;

    localparam logic [6:0] PAT [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h18};

    logic          clk = 1'b0;
    logic          resetn;
    logic [6:0]    seg_in;
    logic [3:0]    digit;
    logic          digit_valid;
    logic          change;
    logic          seq_err;
    logic          bad_pat;
    logic [PW-1:0] period;
    logic          period_valid;
    logic          rate_err;

    hex_digit_monitor #(
        .STABLE_CYCLES(S),
        .PERIOD_W(PW),
        .EXP_PERIOD(EXP),
        .PERIOD_TOL(TOL)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .seg_in(seg_in),
        .digit(digit),
        .digit_valid(digit_valid),
        .change(change),
        .seq_err(seq_err),
        .bad_pat(bad_pat),
        .period(period),
        .period_valid(period_valid),
        .rate_err(rate_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [6:0] hist[$];
    logic [6:0] m_acc;
    int         m_n, m_nsync, m_last_n, m_period;
    logic [3:0] m_digit;
    logic       m_valid, m_change, m_seq, m_bad, m_pv, m_rate;

    // per-row observation counters
    int row_cyc, n_chg, chg_at, n_seq, n_bad, n_rate, n_pv;

    typedef struct {
        logic [6:0] seg;
        int hold, dig, vld, chg, chg_at, seq, bad, rate, pv, per;
    } vec_t;
    vec_t vecs [NV];

    function automatic int dec(input logic [6:0] v);
        for (int i = 0; i < 10; i++) if (PAT[i] == v) return i;
        return -1;
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_acc = 7'h7F;
        m_n = 0; m_nsync = 0; m_last_n = 0; m_period = 0;
        m_digit = 4'd0; m_valid = 1'b0;
        m_change = 0; m_seq = 0; m_bad = 0; m_pv = 0; m_rate = 0;
    endtask

    // Event at edge n iff input samples n-S-1 .. n-2 are all equal and differ from the accepted one.
    task automatic model_edge(input logic [6:0] s);
        logic [6:0] v;
        bit same;
        int d;
        m_n++;
        hist.push_back(s);
        if (hist.size() > S + 2) void'(hist.pop_front());
        m_change = 0; m_seq = 0; m_bad = 0; m_pv = 0; m_rate = 0;
        if (hist.size() == S + 2) begin
            v = hist[0];
            same = 1;
            for (int i = 1; i < S; i++) if (hist[i] != v) same = 0;
            if (same && v != m_acc) begin
                m_acc = v;
                d = dec(v);
                if (d >= 0) begin
                    m_change = 1;
                    if (m_nsync >= 1) begin
                        m_seq    = (d != (int'(m_digit) + 1) % 10);
                        m_period = m_n - m_last_n;
                        m_pv     = 1;
                        if (m_nsync >= 2)
                            m_rate = (m_period < EXP - TOL) || (m_period > EXP + TOL);
                    end
                    m_digit  = 4'(d);
                    m_valid  = 1;
                    m_nsync  = m_nsync + 1;
                    m_last_n = m_n;
                end else begin
                    m_bad   = 1;
                    m_nsync = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string name);
        logic [35:0] act, exp;
        act = {digit, digit_valid, change, seq_err, bad_pat, period, period_valid, rate_err};
        exp = {m_digit, m_valid, m_change, m_seq, m_bad, PW'(m_period), m_pv, m_rate};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: outputs %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge(seg_in);
        #1;
        check_all("cycle");
        if (change === 1'b1) begin
            n_chg++;
            if (chg_at < 0) chg_at = row_cyc;
        end
        if (seq_err === 1'b1) n_seq++;
        if (bad_pat === 1'b1) n_bad++;
        if (rate_err === 1'b1) n_rate++;
        if (period_valid === 1'b1) n_pv++;
        row_cyc++;
    endtask

    task automatic run_seg(input logic [6:0] v, input int hold);
        seg_in = v;
        row_cyc = 0; n_chg = 0; chg_at = -1; n_seq = 0; n_bad = 0; n_rate = 0; n_pv = 0;
        for (int k = 0; k < hold; k++) cycle();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] v;
        int r, h;

        //               seg   hold dig vld chg at seq bad rate pv per
        vecs[0]  = '{7'h40, 20, 0, 1, 1,  5, 0, 0, 0, 0,  0};
        vecs[1]  = '{7'h79, 20, 1, 1, 1,  5, 0, 0, 0, 1, 20};
        vecs[2]  = '{7'h24, 20, 2, 1, 1,  5, 0, 0, 0, 1, 20};
        vecs[3]  = '{7'h30, 20, 3, 1, 1,  5, 0, 0, 0, 1, 20};
        vecs[4]  = '{7'h19, 20, 4, 1, 1,  5, 0, 0, 0, 1, 20};
        vecs[5]  = '{7'h12, 20, 5, 1, 1,  5, 0, 0, 0, 1, 20};
        vecs[6]  = '{7'h02, 20, 6, 1, 1,  5, 0, 0, 0, 1, 20};
        vecs[7]  = '{7'h78, 20, 7, 1, 1,  5, 0, 0, 0, 1, 20};
        vecs[8]  = '{7'h00, 20, 8, 1, 1,  5, 0, 0, 0, 1, 20};
        vecs[9]  = '{7'h18, 20, 9, 1, 1,  5, 0, 0, 0, 1, 20};
        vecs[10] = '{7'h40, 20, 0, 1, 1,  5, 0, 0, 0, 1, 20};
        vecs[11] = '{7'h79, 20, 1, 1, 1,  5, 0, 0, 0, 1, 20};
        vecs[12] = '{7'h24, 20, 2, 1, 1,  5, 0, 0, 0, 1, 20};
        vecs[13] = '{7'h30, 10, 3, 1, 1,  5, 0, 0, 0, 1, 20};
        vecs[14] = '{7'h19,  3, 3, 1, 0, -1, 0, 0, 0, 0, 20};
        vecs[15] = '{7'h30, 10, 3, 1, 0, -1, 0, 0, 0, 0, 20};
        vecs[16] = '{7'h19, 21, 4, 1, 1,  5, 0, 0, 1, 1, 23};
        vecs[17] = '{7'h12, 20, 5, 1, 1,  5, 0, 0, 0, 1, 21};
        vecs[18] = '{7'h24, 20, 2, 1, 1,  5, 1, 0, 0, 1, 20};
        vecs[19] = '{7'h12, 20, 5, 1, 1,  5, 1, 0, 0, 1, 20};
        vecs[20] = '{7'h02, 20, 6, 1, 1,  5, 0, 0, 0, 1, 20};
        vecs[21] = '{7'h7F, 20, 6, 1, 0, -1, 0, 1, 0, 0, 20};
        vecs[22] = '{7'h30, 10, 3, 1, 1,  5, 0, 0, 0, 0, 20};
        vecs[23] = '{7'h19, 20, 4, 1, 1,  5, 0, 0, 0, 1, 10};
        vecs[24] = '{7'h12, 17, 5, 1, 1,  5, 0, 0, 0, 1, 20};
        vecs[25] = '{7'h02, 20, 6, 1, 1,  5, 0, 0, 1, 1, 17};
        vecs[26] = '{7'h78, 22, 7, 1, 1,  5, 0, 0, 0, 1, 20};
        vecs[27] = '{7'h00, 19, 8, 1, 1,  5, 0, 0, 1, 1, 22};
        vecs[28] = '{7'h18, 20, 9, 1, 1,  5, 0, 0, 0, 1, 19};
        vecs[29] = '{7'h40, 20, 0, 1, 1,  5, 0, 0, 0, 1, 20};

        seg_in = 7'h7F;
        resetn = 1'b1;
        model_reset();
        #2;
        do_reset();
        check_int("reset_digit_valid", int'(digit_valid), 0);
        check_int("reset_period", int'(period), 0);

        for (int i = 0; i < NV; i++) begin
            run_seg(vecs[i].seg, vecs[i].hold);
            check_int($sformatf("row%0d_digit", i), int'(digit), vecs[i].dig);
            check_int($sformatf("row%0d_valid", i), int'(digit_valid), vecs[i].vld);
            check_int($sformatf("row%0d_changes", i), n_chg, vecs[i].chg);
            check_int($sformatf("row%0d_change_at", i), chg_at, vecs[i].chg_at);
            check_int($sformatf("row%0d_seq_err", i), n_seq, vecs[i].seq);
            check_int($sformatf("row%0d_bad_pat", i), n_bad, vecs[i].bad);
            check_int($sformatf("row%0d_rate_err", i), n_rate, vecs[i].rate);
            check_int($sformatf("row%0d_period_valid", i), n_pv, vecs[i].pv);
            check_int($sformatf("row%0d_period", i), int'(period), vecs[i].per);
        end

        // reset in the middle of an interval, then a non-zero first digit
        run_seg(7'h79, 7);
        check_int("pre_reset_digit", int'(digit), 1);
        do_reset();
        check_int("midrst_digit", int'(digit), 0);
        check_int("midrst_valid", int'(digit_valid), 0);
        check_int("midrst_period", int'(period), 0);
        run_seg(7'h12, 10);
        check_int("after_rst_digit", int'(digit), 5);
        check_int("after_rst_changes", n_chg, 1);
        check_int("after_rst_seq_err", n_seq, 0);
        check_int("after_rst_pv", n_pv, 0);

        for (int it = 0; it < 150; it++) begin
            r = int'($urandom_range(99, 0));
            if (r < 2) begin
                do_reset();
            end else begin
                if (r < 70) begin
                    v = PAT[(int'(m_digit) + 1) % 10];
                    h = int'($urandom_range(23, 17));
                end else if (r < 80) begin
                    v = PAT[$urandom_range(9, 0)];
                    h = int'($urandom_range(30, 5));
                end else if (r < 88) begin
                    v = 7'($urandom);
                    h = int'($urandom_range(25, 5));
                end else begin
                    v = 7'($urandom);
                    h = int'($urandom_range(3, 1));
                end
                run_seg(v, h);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
